// File: rtl/issue_pkg.sv
// Shared types and sizing for the issue controller and its scoreboard.
package issue_pkg;

  localparam int NREG  = 16;
  localparam int REG_W = $clog2(NREG);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy scoreboard: issue sets a bit, write-back clears it, a new writer wins a tie.
// With WB_BYPASS_EN defined, the hazard mask already excludes the register being written back.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int NREG = issue_pkg::NREG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_i,
  input  logic [$clog2(NREG)-1:0]  set_idx_i,
  input  logic                     clr_i,
  input  logic [$clog2(NREG)-1:0]  clr_idx_i,
  output logic [NREG-1:0]          busy_o,
  output logic [NREG-1:0]          hzd_mask_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_i) set_vec[set_idx_i] = 1'b1;
    if (clr_i) clr_vec[clr_idx_i] = 1'b1;
    // Set is OR-ed in after the clear so a same-cycle reissue keeps the bit.
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

`ifdef WB_BYPASS_EN
  assign hzd_mask_o = busy_q & ~clr_vec;
`else
  assign hzd_mask_o = busy_q;
`endif

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry in-order issue stage with RAW/WAW hazard detection and a stall counter.
// Optional WB_BYPASS_EN lets a held instruction issue in the cycle of its releasing write-back.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int NREG    = issue_pkg::NREG,
  parameter int STALL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREG)-1:0]  in_rd,
  input  logic [$clog2(NREG)-1:0]  in_rs1,
  input  logic [$clog2(NREG)-1:0]  in_rs2,
  input  logic                     in_w,
  input  logic                     in_use_rs2,
  input  logic                     flush,
  input  logic                     wb_valid,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [$clog2(NREG)-1:0]  iss_rd,
  output logic [$clog2(NREG)-1:0]  iss_rs1,
  output logic [$clog2(NREG)-1:0]  iss_rs2,
  output logic                     iss_w,
  output logic [NREG-1:0]          busy_mask,
  output logic [STALL_W-1:0]       stall_cnt
);

  state_e                    state_q;
  logic [$clog2(NREG)-1:0]   rd_q, rs1_q, rs2_q;
  logic                      w_q, use_rs2_q;
  logic [STALL_W-1:0]        stall_q, stall_d;
  logic [NREG-1:0]           hzd_mask;
  logic                      hazard, issue, capture;

  issue_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (issue & w_q),
    .set_idx_i  (rd_q),
    .clr_i      (wb_valid),
    .clr_idx_i  (wb_rd),
    .busy_o     (busy_mask),
    .hzd_mask_o (hzd_mask)
  );

  assign hazard    = hzd_mask[rs1_q] | (use_rs2_q & hzd_mask[rs2_q]) | (w_q & hzd_mask[rd_q]);
  assign iss_valid = (state_q == HELD) & ~hazard & ~flush;
  assign issue     = iss_valid & iss_ready;
  assign in_ready  = ~flush & ((state_q == EMPTY) | issue);
  assign capture   = in_valid & in_ready;

  assign stall_d = ((state_q == HELD) && hazard && (stall_q != {STALL_W{1'b1}}))
                   ? stall_q + STALL_W'(1) : stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      w_q       <= 1'b0;
      use_rs2_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      stall_q <= stall_d;
      if (flush) begin
        state_q <= EMPTY;
      end else if (capture) begin
        state_q   <= HELD;
        rd_q      <= in_rd;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        w_q       <= in_w;
        use_rs2_q <= in_use_rs2;
      end else if (issue) begin
        state_q <= EMPTY;
      end
    end
  end

  assign iss_rd    = rd_q;
  assign iss_rs1   = rs1_q;
  assign iss_rs2   = rs2_q;
  assign iss_w     = w_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: accepted instructions are queued and matched on issue.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic        in_w, in_use_rs2, flush, wb_valid;
  logic [3:0]  wb_rd;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_w;
  logic [15:0] busy_mask;
  logic [7:0]  stall_cnt;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       w;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  issue_ctrl #(.NREG(16), .STALL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_w       (in_w),
    .in_use_rs2 (in_use_rs2),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_rd     (iss_rd),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_w      (iss_w),
    .busy_mask  (busy_mask),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Every observed issue must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (rst_n && iss_valid && iss_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got rd=%0d rs1=%0d rs2=%0d w=%0b, required no issue",
                 iss_rd, iss_rs1, iss_rs2, iss_w);
      end else begin
        e = exp_q.pop_front();
        if ({iss_rd, iss_rs1, iss_rs2, iss_w} !== e) begin
          errors++;
          $display("FAIL issue_fields: got rd=%0d rs1=%0d rs2=%0d w=%0b, required rd=%0d rs1=%0d rs2=%0d w=%0b",
                   iss_rd, iss_rs1, iss_rs2, iss_w, e.rd, e.rs1, e.rs2, e.w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic w, input logic use2, input logic expect_accept);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_w       = w;
    in_use_rs2 = use2;
    if (expect_accept) exp_q.push_back({rd, rs1, rs2, w});
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_w = 0; in_use_rs2 = 0;
    flush = 0; wb_valid = 0; wb_rd = 0; iss_ready = 1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({iss_valid, busy_mask, stall_cnt, iss_rd, iss_rs1, iss_rs2, iss_w} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state: got iss_valid=%0b busy=%h stall=%0d rd=%0d, required all zero",
               iss_valid, busy_mask, stall_cnt, iss_rd);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    step();
    drive_in(3, 1, 2, 1, 1, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %0b, required 1", in_ready); end
    step();
    in_valid = 0;
    #1;
    checks++;
    if (iss_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got iss_valid=%0b, required 1", iss_valid); end
    step();
    checks++;
    if (busy_mask !== 16'h0008) begin errors++; $display("FAIL basic_busy: got %h, required 0008", busy_mask); end
    checks++;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got iss_valid=%0b, required 0", iss_valid); end
    wb_valid = 1; wb_rd = 3;
    step();
    wb_valid = 0;
    #1;
    checks++;
    if (busy_mask !== 16'h0000) begin errors++; $display("FAIL basic_wb_clear: got %h, required 0000", busy_mask); end
  endtask

  task automatic test_raw();
    step();
    drive_in(5, 0, 0, 1, 0, 1);
    step();
    drive_in(7, 5, 0, 0, 0, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_in_ready_on_issue: got %0b, required 1", in_ready); end
    step();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (iss_valid !== 1'b0 || stall_cnt !== 8'(k)) begin
        errors++;
        $display("FAIL raw_stall: got iss_valid=%0b stall=%0d, required 0 and %0d", iss_valid, stall_cnt, k);
      end
      step();
    end
    wb_valid = 1; wb_rd = 5;
    #1;
    checks++;
`ifdef WB_BYPASS_EN
    if (iss_valid !== 1'b1) begin errors++; $display("FAIL raw_bypass_issue: got %0b, required 1", iss_valid); end
    step();
    wb_valid = 0;
`else
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle: got %0b, required 0", iss_valid); end
    step();
    wb_valid = 0;
    #1;
    checks++;
    if (iss_valid !== 1'b1) begin errors++; $display("FAIL raw_issue_after_wb: got %0b, required 1", iss_valid); end
    step();
`endif
    #1;
    checks++;
    if (busy_mask !== 16'h0000 || iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_done: got busy=%h iss_valid=%0b, required 0000 and 0", busy_mask, iss_valid);
    end
  endtask

  task automatic test_waw();
    step();
    drive_in(4, 0, 0, 1, 0, 1);
    step();
    drive_in(4, 1, 4, 1, 0, 1);
    step();
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (iss_valid !== 1'b0) begin errors++; $display("FAIL waw_stall: got iss_valid=%0b, required 0", iss_valid); end
      step();
    end
    wb_valid = 1; wb_rd = 4;
    step();
    wb_valid = 0;
`ifndef WB_BYPASS_EN
    #1;
    checks++;
    if (iss_valid !== 1'b1) begin errors++; $display("FAIL waw_issue: got %0b, required 1", iss_valid); end
    step();
`endif
    #1;
    checks++;
    if (busy_mask !== 16'h0010 || iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL waw_busy: got busy=%h iss_valid=%0b, required 0010 and 0", busy_mask, iss_valid);
    end
    wb_valid = 1; wb_rd = 4;
    step();
    wb_valid = 0;
  endtask

  task automatic test_set_clear();
    step();
    drive_in(6, 0, 0, 1, 0, 1);
    step();
    in_valid = 0;
    wb_valid = 1; wb_rd = 6;
    #1;
    checks++;
    if (iss_valid !== 1'b1) begin errors++; $display("FAIL setclr_issue: got %0b, required 1", iss_valid); end
    step();
    wb_valid = 0;
    #1;
    checks++;
    if (busy_mask !== 16'h0040) begin errors++; $display("FAIL setclr_new_writer_wins: got %h, required 0040", busy_mask); end
    wb_valid = 1; wb_rd = 6;
    step();
    wb_valid = 0;
  endtask

  task automatic test_flush();
    step();
    drive_in(9, 0, 0, 1, 0, 1);
    step();
    drive_in(8, 9, 0, 0, 0, 1);
    step();
    drive_in(11, 0, 0, 1, 0, 0);
    flush = 1;
    #1;
    checks++;
    if (iss_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: got iss_valid=%0b in_ready=%0b, required 0 and 0", iss_valid, in_ready);
    end
    step();
    flush = 0;
    in_valid = 0;
    void'(exp_q.pop_back());
    #1;
    checks++;
    if (in_ready !== 1'b1 || iss_valid !== 1'b0 || busy_mask !== 16'h0200) begin
      errors++;
      $display("FAIL flush_after: got in_ready=%0b iss_valid=%0b busy=%h, required 1 0 0200",
               in_ready, iss_valid, busy_mask);
    end
    wb_valid = 1; wb_rd = 9;
    step();
    wb_valid = 0;
    #1;
    checks++;
    if (busy_mask !== 16'h0000) begin errors++; $display("FAIL flush_retire: got %h, required 0000", busy_mask); end
  endtask

  task automatic test_back_to_back();
    step();
    for (int i = 0; i < 4; i++) begin
      drive_in(4'(i + 1), 4'(i + 2), 4'(i + 3), 1'b0, 1'b1, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %0b, required 1", i, in_ready); end
      step();
    end
    in_valid = 0;
    #1;
    checks++;
    if (iss_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_issue: got %0b, required 1", iss_valid); end
    step();
    drive_in(12, 0, 0, 0, 0, 1);
    step();
    iss_ready = 0;
    drive_in(13, 1, 1, 0, 0, 0);
    #1;
    checks++;
    if (iss_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_backpressure: got iss_valid=%0b in_ready=%0b, required 1 and 0", iss_valid, in_ready);
    end
    step();
    iss_ready = 1;
    exp_q.push_back({4'd13, 4'd1, 4'd1, 1'b0});
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release: got in_ready=%0b, required 1", in_ready); end
    step();
    in_valid = 0;
    step();
  endtask

  task automatic test_saturate();
    step();
    drive_in(10, 0, 0, 1, 0, 1);
    step();
    drive_in(0, 10, 0, 0, 0, 1);
    step();
    in_valid = 0;
    repeat (300) step();
    checks++;
    if (stall_cnt !== 8'd255 || iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_saturate: got stall=%0d iss_valid=%0b, required 255 and 0", stall_cnt, iss_valid);
    end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({iss_valid, busy_mask, stall_cnt, iss_rd, iss_rs1, iss_rs2, iss_w} !== 38'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got iss_valid=%0b busy=%h stall=%0d rs1=%0d in_ready=%0b, required zeros and in_ready 1",
               iss_valid, busy_mask, stall_cnt, iss_rs1, in_ready);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_no_issue: got %0b, required 0", iss_valid); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_waw();
    test_set_clear();
    test_flush();
    test_back_to_back();
    test_saturate();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
